// File: rtl/spi_sclk_seq_if.sv
// spi_sclk_seq_if: bundle for the SPI SCLK/CS sequencer.
//   Inputs  (controller -> sequencer): start_i, cpol_i, cpha_i, div_cfg_i, len_cfg_i,
//                                      lead_cfg_i, lag_cfg_i, hold_i (SPI_SCLK_HOLD_EN only)
//   Outputs (sequencer -> shifter/ctrl): sclk_o, cs_n_o, sample_stb_o, shift_stb_o, busy_o,
//                                        done_o
//   Modports: slave (the sequencer), master (whoever drives the request/config side).
interface spi_sclk_seq_if #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned LEN_W = 6,
    parameter int unsigned DLY_W = 4
);
    logic             start_i;
    logic             cpol_i;
    logic             cpha_i;
    logic [DIV_W-1:0] div_cfg_i;
    logic [LEN_W-1:0] len_cfg_i;
    logic [DLY_W-1:0] lead_cfg_i;
    logic [DLY_W-1:0] lag_cfg_i;
`ifdef SPI_SCLK_HOLD_EN
    logic             hold_i;
`endif
    logic             sclk_o;
    logic             cs_n_o;
    logic             sample_stb_o;
    logic             shift_stb_o;
    logic             busy_o;
    logic             done_o;

    modport slave (
`ifdef SPI_SCLK_HOLD_EN
        input  hold_i,
`endif
        input  start_i, cpol_i, cpha_i, div_cfg_i, len_cfg_i, lead_cfg_i, lag_cfg_i,
        output sclk_o, cs_n_o, sample_stb_o, shift_stb_o, busy_o, done_o
    );

    modport master (
`ifdef SPI_SCLK_HOLD_EN
        output hold_i,
`endif
        output start_i, cpol_i, cpha_i, div_cfg_i, len_cfg_i, lead_cfg_i, lag_cfg_i,
        input  sclk_o, cs_n_o, sample_stb_o, shift_stb_o, busy_o, done_o
    );
endinterface

// File: rtl/spi_sclk_seq.sv
// spi_sclk_seq: SPI serial-clock / chip-select sequencer, one frame per accepted start.
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   bus    : spi_sclk_seq_if.slave -- start/config in; sclk, cs_n, sample/shift strobes,
//            busy and done out (all outputs registered)
// Optional macro SPI_SCLK_HOLD_EN adds bus.hold_i: stalls RUN between bits.
module spi_sclk_seq #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned LEN_W = 6,
    parameter int unsigned DLY_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_sclk_seq_if.slave bus
);
    // Edge counter must reach 2^(LEN_W+1).
    localparam int unsigned EW = LEN_W + 2;

    typedef enum logic [1:0] {StIdle, StLead, StRun, StLag} state_e;

    state_e           state_q, state_d;
    logic             cpol_q, cpol_d, cpha_q, cpha_d;
    logic [DIV_W-1:0] div_q, div_d, div_cnt_q, div_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [DLY_W-1:0] lead_q, lead_d, lag_q, lag_d, dly_cnt_q, dly_cnt_d;
    logic [EW-1:0]    edge_cnt_q, edge_cnt_d;
    logic             sclk_q, sclk_d, cs_n_q, cs_n_d, busy_q, busy_d, done_q, done_d;
    logic             sample_q, sample_d, shift_q, shift_d;

    logic [EW-1:0]    edge_total, edge_num;
    logic             run_hold;

    assign edge_total = (EW'(len_q) + EW'(1)) << 1;
    assign edge_num   = edge_cnt_q + EW'(1);

`ifdef SPI_SCLK_HOLD_EN
    // Only honoured between bits: next edge is leading and the frame is not finished.
    assign run_hold = bus.hold_i && !edge_cnt_q[0] && (edge_cnt_q != edge_total);
`else
    assign run_hold = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        div_d      = div_q;
        len_d      = len_q;
        lead_d     = lead_q;
        lag_d      = lag_q;
        div_cnt_d  = div_cnt_q;
        dly_cnt_d  = dly_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sample_d   = 1'b0;
        shift_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                sclk_d = bus.cpol_i;
                cs_n_d = 1'b1;
                busy_d = 1'b0;
                // A start coinciding with the done pulse is dropped.
                if (bus.start_i && !done_q) begin
                    cpol_d     = bus.cpol_i;
                    cpha_d     = bus.cpha_i;
                    div_d      = bus.div_cfg_i;
                    len_d      = bus.len_cfg_i;
                    lead_d     = bus.lead_cfg_i;
                    lag_d      = bus.lag_cfg_i;
                    dly_cnt_d  = '0;
                    div_cnt_d  = '0;
                    edge_cnt_d = '0;
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = StLead;
                end
            end
            StLead: begin
                if (dly_cnt_q == lead_q) begin
                    div_cnt_d  = '0;
                    edge_cnt_d = '0;
                    state_d    = StRun;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            StRun: begin
                // One settling cycle after the final edge before LAG starts counting.
                if (edge_cnt_q == edge_total) begin
                    dly_cnt_d = '0;
                    state_d   = StLag;
                end else if (!run_hold) begin
                    // Compare before incrementing so div_q = all-ones needs no extra bit.
                    if (div_cnt_q == div_q) begin
                        div_cnt_d  = '0;
                        sclk_d     = ~sclk_q;
                        edge_cnt_d = edge_num;
                        if (edge_num[0]) begin
                            if (cpha_q) shift_d = 1'b1;
                            else        sample_d = 1'b1;
                        end else begin
                            if (cpha_q)                       sample_d = 1'b1;
                            else if (edge_num != edge_total)  shift_d  = 1'b1;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
            end
            StLag: begin
                if (dly_cnt_q == lag_q) begin
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            div_q      <= '0;
            len_q      <= '0;
            lead_q     <= '0;
            lag_q      <= '0;
            div_cnt_q  <= '0;
            dly_cnt_q  <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= bus.cpol_i;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sample_q   <= 1'b0;
            shift_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            div_q      <= div_d;
            len_q      <= len_d;
            lead_q     <= lead_d;
            lag_q      <= lag_d;
            div_cnt_q  <= div_cnt_d;
            dly_cnt_q  <= dly_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sample_q   <= sample_d;
            shift_q    <= shift_d;
        end
    end

    assign bus.sclk_o       = sclk_q;
    assign bus.cs_n_o       = cs_n_q;
    assign bus.sample_stb_o = sample_q;
    assign bus.shift_stb_o  = shift_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
endmodule

// File: tb/tb_spi_sclk_seq.sv
// tb_spi_sclk_seq: directed + randomized frames checked cycle by cycle against a timing model
// derived from the frame-duration and edge-placement rules.
module tb_spi_sclk_seq;
    localparam int unsigned DIV_W = 16;
    localparam int unsigned LEN_W = 6;
    localparam int unsigned DLY_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_sclk_seq_if #(.DIV_W(DIV_W), .LEN_W(LEN_W), .DLY_W(DLY_W)) bus ();

    spi_sclk_seq #(.DIV_W(DIV_W), .LEN_W(LEN_W), .DLY_W(DLY_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model configuration of the frame in flight.
    int m_cpol, m_cpha, m_div, m_len, m_lead, m_lag, m_hb, m_hlen;
    int n_sample, n_shift;

    // Cycle (edges after the accept edge) at which SCLK edge k (1-based) appears.
    function automatic int edge_time(input int k);
        return (m_lead + 1) + k * (m_div + 1) + ((m_hlen > 0 && k > m_hb) ? m_hlen : 0);
    endfunction

    // Accept edge to done edge.
    function automatic int frame_len();
        return 1 + (m_lead + 1) + 2 * (m_len + 1) * (m_div + 1) + (m_lag + 1) + m_hlen;
    endfunction

    // Expected {sclk, cs_n, sample_stb, shift_stb, busy, done} after edge t.
    function automatic logic [5:0] expect_at(input int t);
        int   d;
        int   c;
        int   et;
        logic smp, shf, sck;
        d   = frame_len();
        c   = 0;
        smp = 1'b0;
        shf = 1'b0;
        for (int k = 1; k <= 2 * (m_len + 1); k++) begin
            et = edge_time(k);
            if (et <= t) c++;
            if (et == t) begin
                if (k % 2 == 1) begin
                    if (m_cpha != 0) shf = 1'b1;
                    else             smp = 1'b1;
                end else begin
                    if (m_cpha != 0)            smp = 1'b1;
                    else if (k != 2 * (m_len + 1)) shf = 1'b1;
                end
            end
        end
        sck = ((m_cpol + c) % 2) == 1;
        return {sck, (t >= d), smp, shf, (t < d), (t == d)};
    endfunction

    task automatic check(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {bus.sclk_o, bus.cs_n_o, bus.sample_stb_o, bus.shift_stb_o, bus.busy_o,
               bus.done_o};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b required %b (sclk cs_n smp shf busy done)", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_model(input int cpol, input int cpha, input int div, input int len,
                             input int lead, input int lag, input int hb, input int hlen);
        m_cpol = cpol; m_cpha = cpha; m_div = div; m_len = len;
        m_lead = lead; m_lag = lag; m_hb = hb; m_hlen = hlen;
    endtask

    task automatic drive_cfg();
        bus.cpol_i     = m_cpol[0];
        bus.cpha_i     = m_cpha[0];
        bus.div_cfg_i  = DIV_W'(m_div);
        bus.len_cfg_i  = LEN_W'(m_len);
        bus.lead_cfg_i = DLY_W'(m_lead);
        bus.lag_cfg_i  = DLY_W'(m_lag);
    endtask

    // Runs a frame from acceptance through one idle cycle after done. hb/hlen: hold for hlen
    // cycles right after edge hb (even). mh_bit >= 0: hold across that bit (must be ignored).
    task automatic run_frame(input string name, input int cpol, input int cpha, input int div,
                             input int len, input int lead, input int lag, input int hb,
                             input int hlen, input int mh_bit, input bit keep_start);
        int  d;
        logic h;
        set_model(cpol, cpha, div, len, lead, lag, hb, hlen);
        d = frame_len();
        n_sample = 0;
        n_shift  = 0;
        drive_cfg();
        bus.start_i = 1'b1;
        tick();
        check($sformatf("%s t=0", name), expect_at(0));
        for (int t = 1; t <= d + 1; t++) begin
            if (t < d) begin
                // Scramble everything the sequencer should have latched.
                bus.cpol_i     = 1'($urandom);
                bus.cpha_i     = 1'($urandom);
                bus.div_cfg_i  = DIV_W'($urandom);
                bus.len_cfg_i  = LEN_W'($urandom);
                bus.lead_cfg_i = DLY_W'($urandom);
                bus.lag_cfg_i  = DLY_W'($urandom);
                bus.start_i    = keep_start ? 1'b1 : 1'($urandom);
            end else begin
                bus.cpol_i  = m_cpol[0];
                bus.start_i = keep_start;
            end
            h = (hlen > 0 && t > edge_time(hb) && t <= edge_time(hb) + hlen);
            if (mh_bit >= 0 && t > edge_time(2 * mh_bit + 1) && t <= edge_time(2 * mh_bit + 2))
                h = 1'b1;
            if (t <= m_lead + 1 || t > edge_time(2 * (m_len + 1))) h = 1'($urandom);
`ifdef SPI_SCLK_HOLD_EN
            bus.hold_i = h;
`endif
            tick();
            check($sformatf("%s t=%0d", name, t), expect_at(t));
            n_sample += int'(bus.sample_stb_o);
            n_shift  += int'(bus.shift_stb_o);
        end
`ifdef SPI_SCLK_HOLD_EN
        bus.hold_i = 1'b0;
`endif
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        set_model(0, 0, 0, 0, 0, 0, 0, 0);
        drive_cfg();
        bus.start_i = 1'b0;
`ifdef SPI_SCLK_HOLD_EN
        bus.hold_i = 1'b0;
`endif
        repeat (3) tick();
        check("reset cpol0", 6'b010000);
        bus.cpol_i = 1'b1;
        tick();
        check("reset cpol1", 6'b110000);
        rst_n = 1'b1;
        bus.cpol_i = 1'b0;
        tick();
        check("idle", 6'b010000);

        run_frame("mode0", 0, 0, 0, 0, 0, 0, 0, 0, -1, 1'b0);
        check_int("mode0 samples", n_sample, 1);
        check_int("mode0 shifts", n_shift, 0);

        run_frame("mode3", 1, 1, 1, 7, 2, 1, 0, 0, -1, 1'b0);
        check_int("mode3 samples", n_sample, 8);
        check_int("mode3 shifts", n_shift, 8);

        // Start held across done: next frame accepted one cycle after done.
        run_frame("keepstart", 0, 1, 2, 2, 1, 0, 0, 0, -1, 1'b1);
        run_frame("afterdone", 1, 0, 0, 1, 0, 2, 0, 0, -1, 1'b0);

        run_frame("maxlen", 0, 0, 0, 63, 0, 0, 0, 0, -1, 1'b0);
        check_int("maxlen samples", n_sample, 64);
        check_int("maxlen shifts", n_shift, 63);

        // Reset on the 10th RUN cycle.
        set_model(0, 0, 3, 7, 0, 0, 0, 0);
        drive_cfg();
        bus.start_i = 1'b1;
        tick();
        check("midrst t=0", expect_at(0));
        bus.start_i = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            check($sformatf("midrst t=%0d", t), expect_at(t));
        end
        rst_n = 1'b0;
        tick();
        check("midrst reset", 6'b010000);
        rst_n = 1'b1;
        run_frame("postrst", 0, 0, 1, 2, 0, 0, 0, 0, -1, 1'b0);

`ifdef SPI_SCLK_HOLD_EN
        run_frame("hold5", 0, 0, 1, 3, 0, 0, 2, 5, -1, 1'b0);
        run_frame("holdmid", 1, 1, 2, 3, 1, 1, 0, 0, 2, 1'b0);
`endif

        for (int i = 0; i < 16; i++) begin
            n = $urandom_range(0, 3) == 0 ? $urandom_range(0, 63) : $urandom_range(0, 5);
`ifdef SPI_SCLK_HOLD_EN
            if (n > 0)
                run_frame($sformatf("rnd%0d", i), $urandom_range(0, 1), $urandom_range(0, 1),
                          $urandom_range(0, 3), n, $urandom_range(0, 15), $urandom_range(0, 15),
                          2 * $urandom_range(1, n), $urandom_range(1, 6), -1, 1'b0);
            else
`endif
            run_frame($sformatf("rnd%0d", i), $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 3), n, $urandom_range(0, 15), $urandom_range(0, 15),
                      0, 0, -1, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_sclk_seq.md
Name: spi_sclk_seq

Overview:
- Parametrised successor to the SPI serial-clock divider. Generates SCLK and chip-select for one complete frame per start request.
- Divide ratio is programmable at runtime rather than a fixed table. Supports all four CPOL/CPHA modes, frame lengths of 1 to 2^LEN_W bits, and CS lead/lag delays.
- Emits per-bit sample/shift strobes that the shift register consumes. Sits between the SPI master control registers and the data shifter.

Parameters:
- DIV_W, 16, width of the half-period divide field.
- LEN_W, 6, width of the frame-length field (bits = len_cfg+1, max 64).
- DLY_W, 4, width of the lead/lag delay fields.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- cpol  in  1  idle level of SCLK.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- div_cfg  in  DIV_W  half-period = div_cfg+1 clk cycles.
- len_cfg  in  LEN_W  frame length minus 1, in bits.
- lead_cfg  in  DLY_W  CS-to-first-edge delay minus 1, in clk cycles.
- lag_cfg  in  DLY_W  last-edge-to-CS-release delay minus 1, in clk cycles.
- sclk  out  1  serial clock (registered).
- cs_n  out  1  chip select, active low (registered).
- sample_stb  out  1  one-cycle pulse: shifter samples MISO.
- shift_stb  out  1  one-cycle pulse: shifter drives next MOSI bit.
- busy  out  1  high from start acceptance until frame end.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, sclk=cpol, cs_n=1, busy=0, done=0, both strobes=0, all counters=0. Reset overrides everything, including mid-frame.
- All outputs are registered. The strobes assert in the same cycle sclk toggles.
- IDLE:
  - sclk follows cpol every cycle; cs_n=1.
  - start=1 latches cpol, cpha, div_cfg, len_cfg, lead_cfg and lag_cfg. Next cycle: state=LEAD, cs_n=0, busy=1.
  - Config changes after acceptance have no effect until the next frame.
- LEAD:
  - Cycle counter runs 0..lead_q. At lead_q: state=RUN, div counter=0.
  - LEAD occupies lead_q+1 cycles.
- RUN:
  - Div counter increments each cycle. When it equals div_q: toggle sclk, clear counter, increment edge counter.
  - Edges are numbered 1..2*(len_q+1). Odd edges are leading, even edges are trailing.
  - cpha=0: sample_stb on every leading edge; shift_stb on every trailing edge except the final one.
  - cpha=1: shift_stb on every leading edge; sample_stb on every trailing edge.
  - After the final edge, sclk equals cpol_q, and the next state is LAG with its counter at 0.
- LAG:
  - Runs for lag_q+1 cycles.
  - On exit: cs_n=1, busy=0, done=1 for one cycle, state=IDLE.
- start while busy=1 is ignored and not queued. start in the same cycle done pulses is also ignored; start is sampled again the following cycle.
- Frame duration from the start-accept edge to done: 1 + (lead_q+1) + 2*(len_q+1)*(div_q+1) + (lag_q+1) cycles.
- Counters are exact width with no saturation. div_cfg at all-ones is legal: the half-period is 2^DIV_W cycles and the div counter must be DIV_W+1 bits or compare before incrementing.
- cpha/cpol toggling during a frame has no effect because the latched copies are used.

Optional Feature:
- Macro SPI_SCLK_HOLD_EN adds input port hold (1 bit).
- With the macro defined:
  - In RUN, hold=1 freezes the div counter, but only when the next edge to be produced is a leading edge, i.e. between bits. sclk stays at cpol_q and no strobes fire.
  - Counting resumes the cycle hold falls. hold is ignored during a bit (between its leading and trailing edge) and in IDLE, LEAD and LAG. busy stays high throughout.
- Without the macro: no hold port, and RUN never stalls.

Test Plan:
- Reset mid-frame: start, div_cfg=3, len_cfg=7, lead_cfg=0, lag_cfg=0, cpol=0; rst_n=0 on the 10th cycle of RUN -> next cycle sclk=0, cs_n=1, busy=0, no done; IDLE accepts a new start immediately after rst_n=1.
- Mode 0 basic: cpol=0, cpha=0, div_cfg=0, len_cfg=0, lead_cfg=0, lag_cfg=0 -> cs_n low 1 cycle after accept; sclk high 2 cycles after accept with sample_stb; sclk low the next cycle with no shift_stb; done 5 cycles after accept; total 5 cycles.
- Mode 3 byte: cpol=1, cpha=1, div_cfg=1, len_cfg=7, lead_cfg=2, lag_cfg=1 -> 16 sclk edges, each 2 cycles apart; sclk idles/ends at 1; 8 shift_stb on falling edges and 8 sample_stb on rising edges; frame length 1+3+32+2=38 cycles.
- Config/start while busy: change div_cfg and pulse start mid-frame -> period unchanged, no second frame. start held high across done -> next frame accepted the cycle after done.
- Maximum length: len_cfg=63, div_cfg=0 -> exactly 128 edges, 64 sample_stb, 63 shift_stb (cpha=0); edge counter does not wrap early.
- With SPI_SCLK_HOLD_EN: len_cfg=3; hold=1 for 5 cycles after bit 1's trailing edge -> sclk stays at cpol for 5 extra cycles with no strobes, then bits 2-4 complete; total frame length +5 cycles. hold asserted mid-bit -> no effect.
